// File: rtl/rf_multiport_pkg.sv
// Shared types and default sizes for the multiport register file and its clear engine.
package rf_multiport_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NRD    = 2;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_SWEEP = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_e;

endpackage

// File: rtl/rf_multiport_if.sv
// Write ports A/B, packed read ports and clear handshake of the register file.
interface rf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                  we_a;
    logic [ADDR_W-1:0]     wa_a;
    logic [DATA_W-1:0]     wd_a;
    logic                  we_b;
    logic [ADDR_W-1:0]     wa_b;
    logic [DATA_W-1:0]     wd_b;
    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*DATA_W-1:0] rd;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;

    modport master (
        output we_a, wa_a, wd_a,
        output we_b, wa_b, wd_b,
        output ra, clr_req,
        input  rd, clr_busy, clr_done
    );

    modport slave (
        input  we_a, wa_a, wd_a,
        input  we_b, wa_b, wd_b,
        input  ra, clr_req,
        output rd, clr_busy, clr_done
    );

endinterface

// File: rtl/rf_multiport_clear_ctrl.sv
// Clear engine: walks a counter over every entry, then pulses done for one cycle.
module rf_clear_ctrl
    import rf_multiport_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_idle
);

    rf_state_e         state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The sweep leaves on the last address, so the counter never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt = RF_SWEEP;
                    cnt_nxt   = '0;
                end
            end
            RF_SWEEP: begin
                if (cnt == '1) begin
                    state_nxt = RF_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RF_DONE: begin
                state_nxt = RF_IDLE;
            end
            default: begin
                state_nxt = RF_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign clr_busy = (state == RF_SWEEP);
    assign clr_we   = clr_busy;
    assign clr_addr = cnt;
    assign clr_done = (state == RF_DONE);
    assign clr_idle = (state == RF_IDLE);

endmodule

// File: rtl/rf_multiport.sv
// Two-write, NRD-read register file with optional bypass, hard-wired zero entry and clear sweep.
module rf_multiport
    import rf_multiport_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NRD      = RF_NRD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_multiport_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_port [NRD];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_busy;
    logic              clr_done;
    logic              clr_idle;
    logic              wr_a_ok;
    logic              wr_b_ok;
    logic              byp_en;

    rf_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_idle (clr_idle)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

    assign wr_a_ok = bus.we_a && !((ZERO_REG != 0) && (bus.wa_a == '0));
    assign wr_b_ok = bus.we_b && !((ZERO_REG != 0) && (bus.wa_b == '0));
    assign byp_en  = (BYPASS != 0) && clr_idle;

    // Clear sweep wins over both ports; B is written last so it wins over A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_a_ok) begin
                mem[bus.wa_a] <= bus.wd_a;
            end
            if (wr_b_ok) begin
                mem[bus.wa_b] <= bus.wd_b;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;

        assign addr = bus.ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            rd_port[g] = mem[addr];
            if (byp_en && wr_a_ok && (bus.wa_a == addr)) begin
                rd_port[g] = bus.wd_a;
            end
            if (byp_en && wr_b_ok && (bus.wa_b == addr)) begin
                rd_port[g] = bus.wd_b;
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                rd_port[g] = '0;
            end
        end
    end

    always_comb begin
        bus.rd = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd[i*DATA_W +: DATA_W] = rd_port[i];
        end
    end

endmodule
